// File: rtl/dm_cache_pkg.sv
// Shared types for the direct-mapped cache: geometry defaults, FSM states, line/tag/index types.
package cache_types;

  localparam int S_INDEX  = 3;
  localparam int S_OFFSET = 5;
  localparam int S_TAG    = 32 - S_INDEX - S_OFFSET;

  typedef enum logic [1:0] {
    IDLE,
    TAG_CHECK,
    WRITEBACK,
    ALLOCATE
  } cache_state_t;

  typedef logic [S_TAG-1:0]   tag_t;
  typedef logic [S_INDEX-1:0] index_t;

  // A line viewed as eight 32-bit words; word 0 occupies bits [31:0].
  typedef logic [7:0][31:0] line_t;

endpackage

// File: rtl/dm_cache_array.sv
// Per-set storage: synchronous write, asynchronous read, cleared by reset.
module cache_array #(
  parameter int width   = 1,
  parameter int S_INDEX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [S_INDEX-1:0] windex,
  input  logic [S_INDEX-1:0] rindex,
  input  logic [width-1:0]   datain,
  output logic [width-1:0]   dataout
);

  logic [width-1:0] mem [2**S_INDEX];

  // Write port; reset clears every entry.
  // NOTE: resetting an array forces it into flops rather than RAM macros;
  // acceptable here because the cache must start with every set invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**S_INDEX; i++) mem[i] <= '0;
    end else if (load) begin
      mem[windex] <= datain;
    end
  end

  assign dataout = mem[rindex];

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped, write-back, write-allocate cache: FSM, address split, hit logic, word merge.
module dm_cache
  import cache_types::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  cache_state_t state, next_state;

  tag_t       addr_tag;
  index_t     idx;
  logic [2:0] word_sel;

  assign addr_tag = mem_address[31:S_OFFSET+S_INDEX];
  assign idx      = mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign word_sel = mem_address[4:2];

  line_t data_out, data_in, merged;
  tag_t  tag_out;
  logic  valid_out, dirty_out;
  logic  data_load, meta_load, dirty_load, dirty_in;
  logic  hit;

  cache_array #(.width(256), .S_INDEX(S_INDEX)) data_array (
    .clk, .rst, .load(data_load), .windex(idx), .rindex(idx),
    .datain(data_in), .dataout(data_out)
  );

  cache_array #(.width(S_TAG), .S_INDEX(S_INDEX)) tag_array (
    .clk, .rst, .load(meta_load), .windex(idx), .rindex(idx),
    .datain(addr_tag), .dataout(tag_out)
  );

  cache_array #(.width(1), .S_INDEX(S_INDEX)) valid_array (
    .clk, .rst, .load(meta_load), .windex(idx), .rindex(idx),
    .datain(1'b1), .dataout(valid_out)
  );

  cache_array #(.width(1), .S_INDEX(S_INDEX)) dirty_array (
    .clk, .rst, .load(dirty_load), .windex(idx), .rindex(idx),
    .datain(dirty_in), .dataout(dirty_out)
  );

  assign hit = valid_out && (tag_out == addr_tag);

  // Byte-lane merge of the CPU write data into the selected word of the resident line.
  always_comb begin
    merged = data_out;
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) merged[word_sel][8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state, handshake outputs and array write controls.
  // NOTE: every output gets a default first, so no path through the case leaves a latch.
  always_comb begin
    next_state   = state;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    data_load    = 1'b0;
    data_in      = merged;
    meta_load    = 1'b0;
    dirty_load   = 1'b0;
    dirty_in     = 1'b0;

    unique case (state)
      IDLE: begin
        if (mem_read || mem_write) next_state = TAG_CHECK;
      end
      TAG_CHECK: begin
        if (hit) begin
          mem_resp   = 1'b1;
          next_state = IDLE;
          if (mem_write) begin
            data_load  = 1'b1;
            dirty_load = 1'b1;
            dirty_in   = 1'b1;
          end else begin
            mem_rdata = data_out[word_sel];
          end
        end else begin
          next_state = dirty_out ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_out, idx, {S_OFFSET{1'b0}}};
        pmem_wdata   = data_out;
        if (pmem_resp) next_state = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {addr_tag, idx, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          data_load  = 1'b1;
          data_in    = pmem_rdata;
          meta_load  = 1'b1;
          dirty_load = 1'b1;
          next_state = TAG_CHECK;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dm_cache.sv
// Directed bench for dm_cache with a fixed-latency line memory model.
module tb_dm_cache;

  logic         clk;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int vectors;
  int miscompares;

  // Memory model state and per-request observations.
  logic [255:0] fill_line;
  int           wcnt;
  int           mon_resp;
  int           mon_rd_cycles;
  int           mon_wr_cycles;
  logic [31:0]  mon_rd_addr;
  logic [31:0]  mon_wr_addr;
  logic [255:0] mon_wr_data;
  logic         mon_wr_unstable;
  logic         mon_both;

  dm_cache dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: answers each held strobe on its third cycle; also records observations.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    wcnt       = 0;
    forever begin
      @(negedge clk);
      if (mem_resp) mon_resp++;
      if (pmem_read) begin
        mon_rd_cycles++;
        mon_rd_addr = pmem_address;
      end
      if (pmem_write) begin
        if (mon_wr_cycles == 0) mon_wr_data = pmem_wdata;
        else if (pmem_wdata !== mon_wr_data) mon_wr_unstable = 1'b1;
        mon_wr_cycles++;
        mon_wr_addr = pmem_address;
      end
      if (pmem_read && pmem_write) mon_both = 1'b1;
      if (rst || !(pmem_read || pmem_write)) begin
        pmem_resp = 1'b0;
        wcnt      = 0;
      end else begin
        wcnt++;
        if (wcnt == 3) begin
          pmem_resp  = 1'b1;
          pmem_rdata = fill_line;
          wcnt       = 0;
        end else begin
          pmem_resp = 1'b0;
        end
      end
    end
  end

  task automatic clear_mon();
    mon_resp        = 0;
    mon_rd_cycles   = 0;
    mon_wr_cycles   = 0;
    mon_rd_addr     = '0;
    mon_wr_addr     = '0;
    mon_wr_data     = '0;
    mon_wr_unstable = 1'b0;
    mon_both        = 1'b0;
  endtask

  // Eight words base+i, then one word overridden.
  function automatic logic [255:0] make_line(input logic [31:0] base, input int w, input logic [31:0] val);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + i;
    l[32*w +: 32] = val;
    return l;
  endfunction

  // Issue one CPU request from just after a negedge; lat = negedges until mem_resp (-1 on timeout).
  task automatic do_req(input logic [31:0] a, input logic is_wr, input logic [3:0] be,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd);
    clear_mon();
    mem_address     = a;
    mem_read        = !is_wr;
    mem_write       = is_wr;
    mem_byte_enable = be;
    mem_wdata       = wd;
    lat             = -1;
    rd              = 'x;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (mem_resp) begin
        lat = i;
        rd  = mem_rdata;
        break;
      end
    end
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = '0; mem_wdata = '0;
    fill_line = '0;
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b expected 000", {mem_resp, pmem_read, pmem_write});
    end
    vectors++;
    if (pmem_address !== 32'h0 || mem_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_idle_outputs: got addr %h rdata %h expected 0 0", pmem_address, mem_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_miss();
    int lat; logic [31:0] rd;
    fill_line = make_line(32'h0100_0000, 1, 32'hDEAD_BEEF);
    do_req(32'h0000_0044, 1'b0, 4'h0, 32'h0, lat, rd);
    vectors++;
    if (lat !== 5) begin miscompares++; $display("FAIL miss_latency: got %0d expected 5", lat); end
    vectors++;
    if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL miss_rdata: got %h expected deadbeef", rd); end
    vectors++;
    if (mon_resp !== 1) begin miscompares++; $display("FAIL miss_resp_count: got %0d expected 1", mon_resp); end
    vectors++;
    if (mon_rd_addr !== 32'h0000_0040) begin miscompares++; $display("FAIL miss_fill_addr: got %h expected 00000040", mon_rd_addr); end
    vectors++;
    if (mon_rd_cycles !== 3 || mon_wr_cycles !== 0) begin
      miscompares++;
      $display("FAIL miss_strobe_cycles: got rd %0d wr %0d expected rd 3 wr 0", mon_rd_cycles, mon_wr_cycles);
    end
  endtask

  task automatic test_read_hit();
    int lat; logic [31:0] rd;
    do_req(32'h0000_0044, 1'b0, 4'h0, 32'h0, lat, rd);
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL hit_latency: got %0d expected 1", lat); end
    vectors++;
    if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL hit_rdata: got %h expected deadbeef", rd); end
    vectors++;
    if (mon_rd_cycles !== 0 || mon_wr_cycles !== 0 || mon_resp !== 1) begin
      miscompares++;
      $display("FAIL hit_quiet: got rd %0d wr %0d resp %0d expected 0 0 1", mon_rd_cycles, mon_wr_cycles, mon_resp);
    end
  endtask

  task automatic test_write_hit();
    int lat; logic [31:0] rd;
    do_req(32'h0000_0044, 1'b1, 4'b0011, 32'h0000_CAFE, lat, rd);
    vectors++;
    if (lat !== 1 || mon_resp !== 1) begin
      miscompares++;
      $display("FAIL write_hit_resp: got lat %0d count %0d expected 1 1", lat, mon_resp);
    end
    vectors++;
    if (mon_rd_cycles !== 0 || mon_wr_cycles !== 0) begin
      miscompares++;
      $display("FAIL write_hit_quiet: got rd %0d wr %0d expected 0 0", mon_rd_cycles, mon_wr_cycles);
    end
    do_req(32'h0000_0044, 1'b0, 4'h0, 32'h0, lat, rd);
    vectors++;
    if (rd !== 32'hDEAD_CAFE || lat !== 1) begin
      miscompares++;
      $display("FAIL write_hit_readback: got %h lat %0d expected deadcafe lat 1", rd, lat);
    end
  endtask

  task automatic test_dirty_evict();
    int lat; logic [31:0] rd;
    fill_line = make_line(32'h0200_0000, 1, 32'h5555_0001);
    do_req(32'h0000_0144, 1'b0, 4'h0, 32'h0, lat, rd);
    vectors++;
    if (lat !== 8) begin miscompares++; $display("FAIL evict_latency: got %0d expected 8", lat); end
    vectors++;
    if (mon_wr_addr !== 32'h0000_0040) begin miscompares++; $display("FAIL evict_wb_addr: got %h expected 00000040", mon_wr_addr); end
    vectors++;
    if (mon_wr_data[63:32] !== 32'hDEAD_CAFE || mon_wr_data[31:0] !== 32'h0100_0000 ||
        mon_wr_data[255:224] !== 32'h0100_0007) begin
      miscompares++;
      $display("FAIL evict_wb_data: got w1 %h w0 %h w7 %h expected deadcafe 01000000 01000007",
               mon_wr_data[63:32], mon_wr_data[31:0], mon_wr_data[255:224]);
    end
    vectors++;
    if (mon_wr_unstable !== 1'b0) begin miscompares++; $display("FAIL evict_wb_stable: got %b expected 0", mon_wr_unstable); end
    vectors++;
    if (mon_rd_addr !== 32'h0000_0140) begin miscompares++; $display("FAIL evict_fill_addr: got %h expected 00000140", mon_rd_addr); end
    vectors++;
    if (mon_wr_cycles !== 3 || mon_rd_cycles !== 3 || mon_both !== 1'b0) begin
      miscompares++;
      $display("FAIL evict_strobes: got wr %0d rd %0d both %b expected 3 3 0", mon_wr_cycles, mon_rd_cycles, mon_both);
    end
    vectors++;
    if (rd !== 32'h5555_0001 || mon_resp !== 1) begin
      miscompares++;
      $display("FAIL evict_rdata: got %h count %0d expected 55550001 1", rd, mon_resp);
    end
  endtask

  task automatic test_write_miss();
    int lat; logic [31:0] rd;
    fill_line = make_line(32'h0300_0000, 0, 32'h1234_5678);
    do_req(32'h0000_0260, 1'b1, 4'b1000, 32'hAB00_0000, lat, rd);
    vectors++;
    if (lat !== 5 || mon_resp !== 1) begin
      miscompares++;
      $display("FAIL wmiss_resp: got lat %0d count %0d expected 5 1", lat, mon_resp);
    end
    vectors++;
    if (mon_rd_addr !== 32'h0000_0260 || mon_wr_cycles !== 0) begin
      miscompares++;
      $display("FAIL wmiss_fill: got addr %h wr %0d expected 00000260 0", mon_rd_addr, mon_wr_cycles);
    end
    do_req(32'h0000_0260, 1'b0, 4'h0, 32'h0, lat, rd);
    vectors++;
    if (rd !== 32'hAB34_5678 || lat !== 1) begin
      miscompares++;
      $display("FAIL wmiss_readback: got %h lat %0d expected ab345678 lat 1", rd, lat);
    end
  endtask

  task automatic test_reset_mid_alloc();
    int lat; logic [31:0] rd; logic seen;
    clear_mon();
    seen = 1'b0;
    mem_address = 32'h0000_0084;
    mem_read    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pmem_read) begin seen = 1'b1; break; end
    end
    vectors++;
    if (seen !== 1'b1) begin miscompares++; $display("FAIL rst_alloc_entry: got %b expected 1", seen); end
    #1;
    rst      = 1'b1;
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if ({pmem_read, pmem_write, mem_resp} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_alloc_strobes: got %b expected 000", {pmem_read, pmem_write, mem_resp});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (mon_resp !== 0) begin miscompares++; $display("FAIL rst_alloc_no_resp: got %0d expected 0", mon_resp); end
    fill_line = make_line(32'h0400_0000, 1, 32'h7777_0001);
    do_req(32'h0000_0044, 1'b0, 4'h0, 32'h0, lat, rd);
    vectors++;
    if (lat !== 5 || mon_rd_addr !== 32'h0000_0040 || mon_wr_cycles !== 0) begin
      miscompares++;
      $display("FAIL rst_refill: got lat %0d addr %h wr %0d expected 5 00000040 0", lat, mon_rd_addr, mon_wr_cycles);
    end
    vectors++;
    if (rd !== 32'h7777_0001) begin miscompares++; $display("FAIL rst_refill_rdata: got %h expected 77770001", rd); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_evict();
    test_write_miss();
    test_reset_mid_alloc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
